// File: rtl/dac_update_scheduler.sv
// Round-robin arbiter sharing one DAC channel between code producers: accept, strobe, then settle.
// Optional output saturation to [CLAMP_MIN, CLAMP_MAX] is enabled by defining DAC_SCHED_CLAMP_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for enable and a valid request; req_ready one-hot
// UPDATE  | new code on data_out, dac_strobe high for this cycle
// HOLD    | settling window, hold_cnt counts HOLD_CYCLES-1 down to 0
module dac_update_scheduler #(
    parameter int                    DATA_WIDTH  = 14,
    parameter int                    NUM_REQ     = 4,
    parameter int                    GRANT_WIDTH = 2,
    parameter int                    HOLD_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] MIDSCALE    = 14'h2000,
    parameter logic [DATA_WIDTH-1:0] CLAMP_MIN   = 14'h0000,
    parameter logic [DATA_WIDTH-1:0] CLAMP_MAX   = 14'h3FFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          dac_strobe,
    output logic [GRANT_WIDTH-1:0]        grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_HOLD
    } state_t;

    state_t                 state;
    logic [7:0]             hold_cnt;
    logic [GRANT_WIDTH-1:0] last_grant;
    logic [GRANT_WIDTH-1:0] win_idx;
    logic [GRANT_WIDTH-1:0] rr_idx;
    logic                   win_found;
    logic [DATA_WIDTH-1:0]  win_code;
    logic [DATA_WIDTH-1:0]  code_sel;

    // Search starts just after the previous winner so every requester is reached within NUM_REQ grants.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = GRANT_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    assign win_code = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];

    // Gated by rst_n so no handshake can be seen while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && enable && rst_n && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

`ifdef DAC_SCHED_CLAMP_EN
    always_comb begin
        code_sel = win_code;
        if (win_code < CLAMP_MIN) begin
            code_sel = CLAMP_MIN;
        end else if (win_code > CLAMP_MAX) begin
            code_sel = CLAMP_MAX;
        end
    end
`else
    logic unused_clamp;
    assign code_sel     = win_code;
    assign unused_clamp = ^{CLAMP_MIN, CLAMP_MAX};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            data_out   <= MIDSCALE;
            grant_id   <= '0;
            dac_strobe <= 1'b0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            last_grant <= GRANT_WIDTH'(NUM_REQ - 1);
        end else begin
            dac_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Accept edge: the code goes straight to data_out so it is visible in UPDATE.
                    if (enable && win_found) begin
                        data_out   <= code_sel;
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        dac_strobe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hold_cnt <= 8'(HOLD_CYCLES - 1);
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Self-checking bench for dac_update_scheduler: vector table, hand sequences and a randomized
// run against a cycle-count reference model. Honours DAC_SCHED_CLAMP_EN for expected codes.
module tb_dac_update_scheduler;

    localparam int          DW   = 14;
    localparam int          NR   = 4;
    localparam int          GW   = 2;
    localparam int          HOLD = 8;
    localparam logic [13:0] CMAX = 14'h3000;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    data_out;
    logic             dac_strobe;
    logic [GW-1:0]    grant_id;
    logic             busy;

    int errors = 0;
    int checks = 0;

    dac_update_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .GRANT_WIDTH(GW),
        .HOLD_CYCLES(HOLD),
        .MIDSCALE   (14'h2000),
        .CLAMP_MIN  (14'h0000),
        .CLAMP_MAX  (CMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .data_out  (data_out),
        .dac_strobe(dac_strobe),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [13:0] code;
        int          g;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] exp_code(input logic [13:0] c);
`ifdef DAC_SCHED_CLAMP_EN
        if (c > CMAX) return CMAX;
`endif
        return c;
    endfunction

    // Requester i presents code+i so the winner is visible in data_out as well as grant_id.
    task automatic drive(input logic [3:0] v, input logic [13:0] code);
        req_valid = v;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = code + 14'(i);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int n;
        drive(v.valid, v.code);
        enable = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("vec%0d_ready", id), req_ready, 4'b0001 << v.g);
        @(negedge clk);
        check($sformatf("vec%0d_update", id), {dac_strobe, busy, grant_id, data_out},
              {1'b1, 1'b1, 2'(v.g), exp_code(v.code + 14'(v.g))});
        req_valid = '0;
        n = 1;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_busy_len", id), 64'(n), 64'(HOLD + 1));
        check($sformatf("vec%0d_idle_strobe", id), {63'd0, dac_strobe}, 64'd0);
    endtask

    initial begin
        int n, cyc, ng, last_cyc, r1, winner;
        int m_last, m_free, s_cyc, m_grant;
        logic [13:0] m_data;
        logic [3:0]  pend;
        logic [13:0] pdata [NR];
        logic [3:0]  exp_ready;
        logic        en_ok;

        vecs[0] = '{4'b0100, 14'h1232, 2};
        vecs[1] = '{4'b0011, 14'h0500, 0};
        vecs[2] = '{4'b1010, 14'h0abc, 1};
        vecs[3] = '{4'b1111, 14'h1000, 2};
        vecs[4] = '{4'b1001, 14'h2222, 3};
        vecs[5] = '{4'b1000, 14'h0007, 3};
        vecs[6] = '{4'b0001, 14'h3fff, 0};
        vecs[7] = '{4'b0110, 14'h3100, 1};
        vecs[8] = '{4'b1100, 14'h0000, 2};

        rst_n  = 1'b0;
        enable = 1'b0;
        drive(4'b0000, 14'h0);
        repeat (3) @(negedge clk);
        check("reset_regs", {dac_strobe, busy, grant_id, data_out}, {1'b0, 1'b0, 2'd0, 14'h2000});
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset_ready", req_ready, 4'b0000);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // enable low blocks grants; raising it grants in the same IDLE cycle
        enable = 1'b0;
        drive(4'b0001, 14'h0040);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_ready != '0 || dac_strobe || busy) n++;
            @(negedge clk);
        end
        check("enable_low_blocked", 64'(n), 64'd0);
        enable = 1'b1;
        #1;
        check("enable_rise_ready", req_ready, 4'b0001);
        @(negedge clk);
        check("enable_rise_update", {dac_strobe, grant_id, data_out}, {1'b1, 2'd0, exp_code(14'h0040)});
        req_valid = '0;

        // asynchronous reset in the middle of HOLD
        repeat (4) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        drive(4'b1111, 14'h0100);
        #3;
        rst_n = 1'b0;
        #1;
        check("midhold_reset", {dac_strobe, busy, req_ready, data_out}, {1'b0, 1'b0, 4'b0000, 14'h2000});
        @(negedge clk);
        @(negedge clk);
        check("midhold_reset_ready", req_ready, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", req_ready, 4'b0001);

        // fairness and back-pressure with all four requesters valid
        cyc = 0;
        ng = 0;
        last_cyc = 0;
        r1 = 0;
        while (ng < 8 && cyc < 200) begin
            if (req_ready[1]) r1++;
            @(negedge clk);
            cyc++;
            if (dac_strobe) begin
                check($sformatf("fair_grant%0d", ng), {grant_id, data_out},
                      {2'(ng % 4), exp_code(14'h0100 + 14'(ng % 4))});
                if (ng > 0) check($sformatf("fair_spacing%0d", ng), 64'(cyc - last_cyc), 64'(HOLD + 2));
                last_cyc = cyc;
                ng++;
            end
            #1;
        end
        check("fair_count", 64'(ng), 64'd8);
        check("backpressure_ready1_pulses", 64'(r1), 64'd2);
        req_valid = '0;
        wait_idle();

        // randomized run against a cycle-count model
        enable = 1'b0;
        drive(4'b0000, 14'h0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_last  = NR - 1;
        m_free  = 0;
        s_cyc   = -100;
        m_grant = 0;
        m_data  = 14'h2000;
        pend    = '0;
        for (int i = 0; i < NR; i++) pdata[i] = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            check("rand_regs", {dac_strobe, busy, grant_id, data_out},
                  {(c == s_cyc), (c >= s_cyc && c <= s_cyc + HOLD), 2'(m_grant), m_data});
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 14'($urandom);
                end
                req_data[i*DW +: DW] = pend[i] ? pdata[i] : 14'($urandom);
            end
            req_valid = pend;
            en_ok  = ($urandom_range(0, 7) != 0);
            enable = en_ok;
            #1;
            winner = -1;
            if (c >= m_free && en_ok) begin
                for (int k = 1; k <= NR; k++) begin
                    if (winner < 0 && pend[(m_last + k) % NR]) winner = (m_last + k) % NR;
                end
            end
            exp_ready = (winner >= 0) ? (4'b0001 << winner) : 4'b0000;
            check("rand_ready", req_ready, exp_ready);
            if (winner >= 0) begin
                s_cyc   = c + 1;
                m_grant = winner;
                m_data  = exp_code(pdata[winner]);
                m_last  = winner;
                m_free  = c + 2 + HOLD;
                pend[winner] = 1'b0;
            end
        end

        req_valid = '0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
